// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: opcode classes,
// the undecoded-opcode window and the loader state encoding.
package prog_loader_pkg;

  localparam logic [5:0] OP_LDI     = 6'b100000;
  localparam logic [5:0] OP_SW      = 6'b111100;  // low two bits select a register
  localparam logic [5:0] ILLEGAL_LO = 6'b101010;
  localparam logic [5:0] ILLEGAL_HI = 6'b110111;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_W_HI,
    ST_W_LO,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  // True for opcode classes the control unit has no decode for.
  function automatic logic is_undecoded(input logic [5:0] op);
    return (op >= ILLEGAL_LO) && (op <= ILLEGAL_HI);
  endfunction

endpackage

// File: rtl/prog_loader_csum.sv
// Running XOR of the image bytes; cleared when a load starts.
module loader_csum (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] acc
);

  always_ff @(posedge clk) begin
    if (clr)
      acc <= 8'h00;
    else if (en)
      acc <= acc ^ din;
  end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: byte stream -> big-endian 16-bit words written
// into program memory, with length and XOR checksum validation.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [15:0]       pm_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic              bad_op
);

  state_t             state, state_nxt;
  logic [7:0]         hi_byte;
  logic [15:0]        len;
  logic [16:0]        count;
  logic [ADDR_W-1:0]  addr;
  logic [7:0]         csum;

  logic               accept;
  logic               start_ok;
  logic [15:0]        len_in;
  logic               len_big;
  logic [16:0]        count_inc;
  logic               last_word;
  logic               chk_match;

  assign accept    = rx_valid && rx_ready;
  assign start_ok  = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
  assign len_in    = {hi_byte, rx_data};
  // 17-bit compare so a full 2^ADDR_W-word image is still accepted
  assign len_big   = {1'b0, len_in} > (17'd1 << ADDR_W);
  assign count_inc = count + 17'd1;
  assign last_word = (count_inc == {1'b0, len});
  assign chk_match = (rx_data == csum);

  loader_csum u_csum (
    .clk (clk),
    .clr (start_ok),
    .en  (accept && state != ST_CHK),
    .din (rx_data),
    .acc (csum)
  );

  always_comb begin
    rx_ready = 1'b0;
    case (state)
      ST_LEN_HI, ST_LEN_LO, ST_W_HI, ST_W_LO, ST_CHK: rx_ready = 1'b1;
      default:                                        rx_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_nxt = ST_LEN_HI;
      ST_LEN_HI: if (accept) state_nxt = ST_LEN_LO;
      ST_LEN_LO: begin
        if (accept) begin
          if (len_big)             state_nxt = ST_ERR;
          else if (len_in == 16'd0) state_nxt = ST_CHK;
          else                     state_nxt = ST_W_HI;
        end
      end
      ST_W_HI:  if (accept) state_nxt = ST_W_LO;
      ST_W_LO:  if (accept) state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = last_word ? ST_CHK : ST_W_HI;
      ST_CHK:   if (accept) state_nxt = chk_match ? ST_DONE : ST_ERR;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pm_we    <= 1'b0;
      pm_addr  <= '0;
      pm_wdata <= 16'h0000;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      bad_op   <= 1'b0;
      count    <= 17'd0;
      addr     <= '0;
    end else begin
      pm_we <= (state == ST_W_LO) && accept;
      if (start_ok) begin
        count    <= 17'd0;
        addr     <= '0;
        done     <= 1'b0;
        err      <= 1'b0;
        bad_op   <= 1'b0;
        cpu_hold <= 1'b1;
      end
      if (state == ST_LEN_LO && accept && len_big)
        err <= 1'b1;
      if (state == ST_W_LO && accept) begin
        pm_addr  <= addr;
        pm_wdata <= len_in;
      end
      // The word is flagged but still written.
      if (state == ST_WRITE) begin
        addr  <= addr + ADDR_W'(1);
        count <= count_inc;
        if (is_undecoded(pm_wdata[15:10]))
          bad_op <= 1'b1;
      end
      if (state == ST_CHK && accept) begin
        if (chk_match) begin
          done     <= 1'b1;
          cpu_hold <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_LEN_HI && accept)
      hi_byte <= rx_data;
    else if (state == ST_W_HI && accept)
      hi_byte <= rx_data;
    if (state == ST_LEN_LO && accept)
      len <= len_in;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a small program-memory model.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          pm_we;
  logic [AW-1:0] pm_addr;
  logic [15:0]   pm_wdata;
  logic          cpu_hold, done, err, bad_op;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int rdy_in_wr = 0;
  int we_base;
  logic [AW-1:0] last_addr = '0;
  logic [15:0]   mem [16];
  bit            bp = 1'b0;

  prog_loader #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .pm_we    (pm_we),
    .pm_addr  (pm_addr),
    .pm_wdata (pm_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err),
    .bad_op   (bad_op)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pm_we) begin
      mem[pm_addr] <= pm_wdata;
      last_addr    <= pm_addr;
      we_cnt       <= we_cnt + 1;
      if (rx_ready) rdy_in_wr <= rdy_in_wr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for rx_ready, presents one byte for one edge; returns #1 after accept.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    if (bp) @(negedge clk);
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rx_ready_timeout", n < 50, 1);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_pm_we", pm_we, 0);
    chk("rst_pm_addr", pm_addr, 0);
    chk("rst_pm_wdata", pm_wdata, 0);
    chk("rst_cpu_hold", cpu_hold, 0);
    chk("rst_flags", {done, err, bad_op}, 3'b000);
    @(negedge clk) reset = 1'b0;

    // Normal load: 00 02 | 80 15 | 84 00 | 13
    we_base = we_cnt;
    pulse_start();
    chk("norm_hold_on_start", cpu_hold, 1);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h80); send_byte(8'h15);
    chk("norm_w0_we", pm_we, 1);
    chk("norm_w0_addr", pm_addr, 0);
    chk("norm_w0_data", pm_wdata, 16'h8015);
    chk("norm_w0_ready_low", rx_ready, 0);
    send_byte(8'h84); send_byte(8'h00);
    chk("norm_w1_addr", pm_addr, 1);
    chk("norm_w1_data", pm_wdata, 16'h8400);
    send_byte(8'h13);
    chk("norm_done", done, 1);
    chk("norm_err", err, 0);
    chk("norm_hold", cpu_hold, 0);
    chk("norm_bad_op", bad_op, 0);
    chk("norm_we_count", we_cnt - we_base, 2);
    chk("norm_mem0", mem[0], 16'h8015);
    chk("norm_mem1", mem[1], 16'h8400);

    // Checksum error: same image, CHK=00
    we_base = we_cnt;
    pulse_start();
    chk("cerr_done_cleared", done, 0);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h80); send_byte(8'h15);
    send_byte(8'h84); send_byte(8'h00);
    send_byte(8'h00);
    chk("cerr_err", err, 1);
    chk("cerr_done", done, 0);
    chk("cerr_hold", cpu_hold, 1);
    chk("cerr_we_count", we_cnt - we_base, 2);
    pulse_start();
    chk("cerr_restart_err", err, 0);
    chk("cerr_restart_hold", cpu_hold, 1);

    // Oversize length 17 > 16 from the restart above
    we_base = we_cnt;
    send_byte(8'h00); send_byte(8'h11);
    chk("big_err", err, 1);
    chk("big_state", dut.state, ST_ERR);
    repeat (3) @(posedge clk);
    #1;
    chk("big_no_ready", rx_ready, 0);
    chk("big_no_we", we_cnt - we_base, 0);
    chk("big_hold", cpu_hold, 1);

    // Zero-length image
    we_base = we_cnt;
    pulse_start();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    chk("zero_done", done, 1);
    chk("zero_err", err, 0);
    chk("zero_no_we", we_cnt - we_base, 0);

    // One undecoded-class word 0xA800, CHK = 01^A8 = A9
    we_base = we_cnt;
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hA8); send_byte(8'h00);
    chk("ill_wdata", pm_wdata, 16'hA800);
    send_byte(8'hA9);
    chk("ill_done", done, 1);
    chk("ill_bad_op", bad_op, 1);
    chk("ill_mem0", mem[0], 16'hA800);
    chk("ill_we_count", we_cnt - we_base, 1);

    // Backpressure: idle cycle with rx_valid low before each byte
    we_base = we_cnt;
    bp = 1'b1;
    pulse_start();
    chk("bp_bad_op_cleared", bad_op, 0);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h80); send_byte(8'h15);
    send_byte(8'h84); send_byte(8'h00);
    send_byte(8'h13);
    bp = 1'b0;
    chk("bp_done", done, 1);
    chk("bp_mem0", mem[0], 16'h8015);
    chk("bp_mem1", mem[1], 16'h8400);
    chk("bp_we_count", we_cnt - we_base, 2);
    chk("bp_ready_in_write", rdy_in_wr, 0);

    // Reset right after the first W_LO byte
    we_base = we_cnt;
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h80); send_byte(8'h15);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_state", dut.state, ST_IDLE);
    chk("mrst_outputs", {rx_ready, pm_we, cpu_hold, done, err, bad_op}, 6'b000000);
    chk("mrst_pm_addr", pm_addr, 0);
    chk("mrst_pm_wdata", pm_wdata, 0);
    chk("mrst_we_count", we_cnt - we_base, 1);
    chk("mrst_last_addr", last_addr, 0);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_stays_idle", dut.state, ST_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader for the 16-bit CPU: receives a byte stream over a valid/ready interface, assembles big-endian 16-bit instruction words, and writes them into program memory. It produces the words that the control unit later decodes. It holds the CPU stalled while loading, validates the image length and XOR checksum, and flags opcode classes that the control unit does not decode. It sits between the host byte link (UART/JTAG bridge) and the program-memory write port.

## Interface
Parameters:
- ADDR_W, 10, program-memory address width; capacity 2^ADDR_W words.

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1, system clock; all state changes on its rising edge.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle pulse; begins a load when in IDLE, DONE or ERR.
- rx_data, in, 8, incoming byte.
- rx_valid, in, 1, rx_data is valid.
- rx_ready, out, 1, loader accepts a byte this cycle.
- pm_we, out, 1, program-memory write strobe.
- pm_addr, out, ADDR_W, write address.
- pm_wdata, out, 16, instruction word.
- cpu_hold, out, 1, stalls the CPU; PC reset is driven from this signal.
- done, out, 1, level; image loaded and checksum matched.
- err, out, 1, level; length or checksum failure.
- bad_op, out, 1, sticky; at least one written word used an undecoded opcode class.

## Operation
- Stream format:
  - LEN_HI, LEN_LO: word count N, big-endian, 16 bits.
  - N × (W_HI, W_LO): instruction words.
  - CHK: one byte equal to the XOR of every preceding byte in the stream.
- States: IDLE, LEN_HI, LEN_LO, W_HI, W_LO, WRITE, CHK, DONE, ERR.
- IDLE/DONE/ERR + start → LEN_HI. On this transition: clear count, addr, xor accumulator, done, err and bad_op; set cpu_hold=1.
- A byte is consumed on a rising edge with rx_valid && rx_ready. Each consumed byte except CHK is XORed into the accumulator.
- Length checks after LEN_LO:
  - N > 2^ADDR_W → ERR.
  - N = 0 → CHK.
  - Otherwise → W_HI.
- W_LO accept → WRITE: pm_we=1 for exactly one cycle with registered pm_addr and pm_wdata. Next cycle, addr and count increment. If count == N → CHK, else → W_HI.
- CHK accept: the byte equals the accumulator → DONE (cpu_hold=0, done=1); otherwise → ERR (cpu_hold stays 1, err=1).
- bad_op is set in WRITE when pm_wdata[15:10] lies in 6'b101010..6'b110111 (codes the control unit leaves undecoded). The word is still written.
- start is ignored in every state other than IDLE/DONE/ERR.
- Outputs are registered; rx_ready is a decode of the state register.

## Timing
- Reset values: rx_ready=0, pm_we=0, pm_addr=0, pm_wdata=0, cpu_hold=0, done=0, err=0, bad_op=0. State returns to IDLE.
- Reset mid-load abandons the load. Any words already written remain in memory. The CPU is released (cpu_hold=0).
- rx_ready=1 only in LEN_HI, LEN_LO, W_HI, W_LO and CHK.
- Minimum per-word cost is 3 cycles (W_HI, W_LO, WRITE). Minimum total load time is 2 + 3N + 1 cycles plus the start cycle.
- pm_we pulses 1 cycle after the W_LO byte is accepted.
- done/err change 1 cycle after the CHK byte is accepted. cpu_hold falls on the same edge that sets done.
- Address wrap cannot occur: the length check bounds the address to 2^ADDR_W−1.
- rx_valid low stalls the FSM indefinitely with no timeout. start during a stall is ignored.

## Structure
- cpu_pkg: opcode-class constants (OP_LDI=6'b100000 … OP_SW=6'b1111zz), ILLEGAL_LO=6'b101010, ILLEGAL_HI=6'b110111, and the state enum.
- One natural sub-module, loader_csum: byte XOR accumulator with clear/enable, 8-bit output.

## Test plan
- Normal load: start; stream 00 02 | 80 15 | 84 00 | CHK=0x13. Required: writes 0x8015 to addr 0 and 0x8400 to addr 1; done=1; cpu_hold=0; bad_op=0.
- Checksum error: same stream with CHK=0x00. Required: both writes occur, err=1, done=0, cpu_hold=1. A new start clears err.
- Oversize length: ADDR_W=4, LEN=00 11 (17). Required: ERR immediately after LEN_LO, no pm_we pulse, CHK byte not requested (rx_ready=0).
- Zero length plus undecoded opcode: stream 00 00 | 00 → done=1 with no writes. Then a load of N=1, word 0xA800 with matching CHK → word written, bad_op=1, done=1.
- Backpressure: rx_valid toggled 1/0 each cycle during the normal load. Required: identical memory contents. pm_we asserts exactly twice. rx_ready is never high in WRITE.
- Reset mid-load: assert reset after the first W_LO byte is accepted. Required: next cycle all outputs are at their reset values, state is IDLE, and only addr 0 has been written.
